// File: rtl/seg7_scan_if.sv
// Bus between a digit-word producer and the multiplexed seven-segment driver.
// The master drives the digit word and controls; the slave returns the pin-level display signals.
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    en;
  logic                    load;
  logic                    lz_en;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic [6:0]              seg_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   an_out;
  logic [IDX_W-1:0]        digit_idx;

  modport master (
    output en, load, lz_en, digits_in, dp_in, blank_in,
    input  seg_out, dp_out, an_out, digit_idx
  );

  modport slave (
    input  en, load, lz_en, digits_in, dp_in, blank_in,
    output seg_out, dp_out, an_out, digit_idx
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: latches a packed digit word and scans one digit per slot,
// with hex/decimal glyphs, dp and blank masks, leading-zero suppression, dead time and pin polarity.
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 1000,
  parameter int DEAD_CYC       = 2,
  parameter bit HEX_MODE       = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  seg7_scan_if.slave  bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]      CNT_DEAD = CNT_W'(DEAD_CYC);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF   = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  // Segment glyph for one code, active-high, bit0=a .. bit6=g.
  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    s = 7'h00;
    case (code)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h27;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    if (!HEX_MODE && code > 4'd9) s = 7'h00;
    return s;
  endfunction

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_out_q, dp_out_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;

  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [3:0]              cur_code;
  logic                    cur_dp;
  logic                    cur_blank;
  logic                    cur_lz;
  logic [6:0]              seg_raw;
  logic                    dp_raw;
  logic [NUM_DIGITS-1:0]   an_raw;

  // Slot timing: cnt walks through one slot, idx advances at the slot boundary.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (bus.en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    digits_d = digits_q;
    dp_d     = dp_q;
    blank_d  = blank_q;
    if (bus.load) begin
      digits_d = bus.digits_in;
      dp_d     = bus.dp_in;
      blank_d  = bus.blank_in;
    end
  end

  // Walk from the most significant digit down; a digit is suppressed while every digit
  // from it upward reads as zero (blanked digits count as zero). Digit 0 always shows.
  always_comb begin
    logic run;
    run     = 1'b1;
    lz_mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run        = run & (blank_q[k] | (digits_q[4*k +: 4] == 4'h0));
      lz_mask[k] = bus.lz_en & run & (k != 0);
    end
  end

  // Mux out the active digit; compare-based select keeps idx values past NUM_DIGITS-1 harmless.
  always_comb begin
    cur_code  = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_lz    = 1'b0;
    an_raw    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_code  = digits_q[4*k +: 4];
        cur_dp    = dp_q[k];
        cur_blank = blank_q[k];
        cur_lz    = lz_mask[k];
        an_raw[k] = 1'b1;
      end
    end
  end

  // Blank mask beats zero suppression; suppression keeps the decimal point.
  always_comb begin
    seg_raw = 7'h00;
    dp_raw  = 1'b0;
    if (bus.en) begin
      if (cur_blank) begin
        seg_raw = 7'h00;
        dp_raw  = 1'b0;
      end else if (cur_lz) begin
        seg_raw = 7'h00;
        dp_raw  = cur_dp;
      end else begin
        seg_raw = decode(cur_code);
        dp_raw  = cur_dp;
      end
    end
    seg_d       = seg_raw ^ SEG_OFF;
    dp_out_d    = dp_raw ^ DP_OFF;
    an_d        = ((bus.en && cnt_q >= CNT_DEAD) ? an_raw : '0) ^ AN_OFF;
    digit_idx_d = idx_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: the shadow word is a handful of flops, so it takes the async reset like everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      digits_q    <= '0;
      dp_q        <= '0;
      blank_q     <= '0;
      seg_q       <= SEG_OFF;
      dp_out_q    <= DP_OFF;
      an_q        <= AN_OFF;
      digit_idx_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      digits_q    <= digits_d;
      dp_q        <= dp_d;
      blank_q     <= blank_d;
      seg_q       <= seg_d;
      dp_out_q    <= dp_out_d;
      an_q        <= an_d;
      digit_idx_q <= digit_idx_d;
    end
  end

  assign bus.seg_out   = seg_q;
  assign bus.dp_out    = dp_out_q;
  assign bus.an_out    = an_q;
  assign bus.digit_idx = digit_idx_q;

endmodule
